avr_io_ps2: RTL and testbench

PS/2 keyboard receiver peripheral on the AVR core's I/O bus. It deserialises frames from the board's PS2Clk/PS2Data pins, buffers the received bytes in a 4-entry FIFO, and presents data/status/control registers to the core. It raises a level interrupt into the top-level priority encoder. The top level decodes I/O addresses 0x14–0x17 (`io_a[5:2] == 4'b0101`) and gates `io_re`/`io_we` to this block, the same way it does for the UART.

---
 rtl/avr_io_ps2_if.sv | 14 +
 rtl/avr_io_ps2.sv | 184 ++++++++++++++++++
 tb/tb_avr_io_ps2.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/avr_io_ps2_if.sv
// I/O-bus connection between the AVR core and the PS/2 receiver peripheral.
interface avr_io_ps2_if;
    logic       io_re;
    logic       io_we;
    logic [1:0] io_a;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       irq;

    modport master (output io_re, output io_we, output io_a, output io_din,
                    input  io_dout, input irq);
    modport slave  (input  io_re, input  io_we, input  io_a, input  io_din,
                    output io_dout, output irq);
endinterface

// File: rtl/avr_io_ps2.sv
// PS/2 keyboard receiver: pin conditioning, frame FSM, 4-deep byte FIFO and
// DATA/STATUS/CTRL registers on the AVR I/O bus with a level interrupt.
module avr_io_ps2 #(
    parameter int unsigned FILT    = 4,
    parameter int unsigned TIMEOUT = 12500
) (
    input  logic         clk,
    input  logic         rst,
    avr_io_ps2_if.slave  bus,
    input  logic         ps2_clk,
    input  logic         ps2_data
);
    localparam int unsigned FCW = (FILT > 1)    ? $clog2(FILT)    : 1;
    localparam int unsigned TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DEPTH = 4;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Reset asserts immediately, releases two clocks after rst rises.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [1:0] clk_sync, dat_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Filtered clock follows the pin only after FILT consecutive differing samples.
    logic           filt, filt_d, fall, din_s;
    logic [FCW-1:0] fcnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (clk_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILT - 1)) begin
                filt <= clk_sync[1];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FCW'(1);
            end
        end
    end
    assign fall  = filt_d & ~filt;
    assign din_s = dat_sync[1];

    logic [1:0] ctrl;
    logic       en, rxie;
    assign en   = ctrl[0];
    assign rxie = ctrl[1];

    state_t         state;
    logic [2:0]     bitcnt;
    logic [7:0]     shreg;
    logic           par;
    logic [TCW-1:0] tcnt;
    logic           frame_end, frame_good, frame_bad;

    assign frame_end  = (state == S_STOP) && fall && en;
    assign frame_good = frame_end && din_s && (^{par, shreg});
    assign frame_bad  = frame_end && !frame_good;

    // Frame receiver; a stalled frame is dropped after TIMEOUT idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            tcnt   <= '0;
        end else if (!en) begin
            state <= S_IDLE;
            tcnt  <= '0;
        end else if (fall) begin
            tcnt <= '0;
            case (state)
                S_IDLE: begin
                    if (!din_s) begin
                        state  <= S_DATA;
                        bitcnt <= '0;
                    end
                end
                S_DATA: begin
                    shreg  <= {din_s, shreg[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state <= S_PARITY;
                end
                S_PARITY: begin
                    par   <= din_s;
                    state <= S_STOP;
                end
                default: state <= S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (tcnt == TCW'(TIMEOUT - 1)) begin
                state <= S_IDLE;
                tcnt  <= '0;
            end else begin
                tcnt <= tcnt + TCW'(1);
            end
        end else begin
            tcnt <= '0;
        end
    end

    logic [7:0] mem [DEPTH];
    logic [1:0] rp, wp;
    logic [2:0] count, count_n;
    logic       ovf, perr, irq_q;
    logic       pop, push_ok, ovf_evt, st_wr, ctrl_wr;
    logic [1:0] ctrl_n;

    assign pop     = bus.io_re && (bus.io_a == 2'd0) && (count != 3'd0);
    assign push_ok = frame_good && ((count != 3'd4) || pop);
    assign ovf_evt = frame_good && (count == 3'd4) && !pop;
    assign st_wr   = bus.io_we && (bus.io_a == 2'd1);
    assign ctrl_wr = bus.io_we && (bus.io_a == 2'd2);
    assign ctrl_n  = ctrl_wr ? bus.io_din[1:0] : ctrl;

    always_comb begin
        count_n = count;
        if (push_ok && !pop)      count_n = count + 3'd1;
        else if (!push_ok && pop) count_n = count - 3'd1;
    end

    // FIFO, sticky flags, CTRL and the registered interrupt; a new error beats its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            perr  <= 1'b0;
            ctrl  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wp] <= shreg;
                wp      <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            count <= count_n;
            ovf   <= ovf_evt   | (ovf  & ~(st_wr & bus.io_din[1]));
            perr  <= frame_bad | (perr & ~(st_wr & bus.io_din[2]));
            ctrl  <= ctrl_n;
            irq_q <= ctrl_n[0] & ctrl_n[1] & (count_n != 3'd0);
        end
    end

    logic [7:0] dout;
    always_comb begin
        dout = 8'h00;
        if (bus.io_re) begin
            case (bus.io_a)
                2'd0:    dout = (count != 3'd0) ? mem[rp] : 8'h00;
                2'd1:    dout = {1'b0, count, (count == 3'd4), perr, ovf, (count != 3'd0)};
                2'd2:    dout = {6'b0, rxie, en};
                default: dout = 8'h00;
            endcase
        end
    end

    assign bus.io_dout = dout;
    assign bus.irq     = irq_q;

    logic unused_din;
    assign unused_din = ^bus.io_din[7:3];
endmodule

// File: tb/tb_avr_io_ps2.sv
// Randomised scoreboard bench for avr_io_ps2 against a queue-based register model.
module tb_avr_io_ps2;
    localparam int unsigned FILT    = 4;
    localparam int unsigned TIMEOUT = 200;
    localparam int          H       = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    always #5 clk = ~clk;

    avr_io_ps2_if bus();

    avr_io_ps2 #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ps2_clk(ps2_clk), .ps2_data(ps2_data));

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned m_fifo[$];
    bit m_ovf = 0, m_perr = 0, m_en = 0, m_rxie = 0;

    function automatic logic [7:0] m_status();
        int n = m_fifo.size();
        return {1'b0, 3'(n), (n == 4), m_perr, m_ovf, (n != 0)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus read is compared with the model; writes update the model.
    always @(negedge clk) begin : monitor
        logic [7:0] exp;
        if (bus.io_re) begin
            if (bus.io_a == 2'd0) begin
                exp = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
                check("DATA", bus.io_dout, exp);
                if (m_fifo.size() != 0) void'(m_fifo.pop_front());
            end else if (bus.io_a == 2'd1) begin
                check("STATUS", bus.io_dout, m_status());
            end else if (bus.io_a == 2'd2) begin
                check("CTRL", bus.io_dout, {6'b0, m_rxie, m_en});
            end else begin
                check("REG3", bus.io_dout, 8'h00);
            end
        end
        if (bus.io_we && rst) begin
            if (bus.io_a == 2'd1) begin
                if (bus.io_din[1]) m_ovf  = 0;
                if (bus.io_din[2]) m_perr = 0;
            end else if (bus.io_a == 2'd2) begin
                m_en   = bus.io_din[0];
                m_rxie = bus.io_din[1];
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [1:0] a);
        bus.io_re = 1'b1;
        bus.io_a  = a;
        cyc();
        bus.io_re = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.io_we  = 1'b1;
        bus.io_a   = a;
        bus.io_din = d;
        cyc();
        bus.io_we  = 1'b0;
    endtask

    task automatic check_irq();
        check("IRQ", {7'b0, bus.irq}, {7'b0, m_en & m_rxie & (m_fifo.size() != 0)});
    endtask

    // One PS/2 bit cell; optional 2-cycle glitch in the high phase, optional DATA read
    // aligned to the cycle in which the falling edge is acted on.
    task automatic send_bit(input logic b, input bit glitch, input bit rd_at_fall);
        ps2_data = b;
        if (glitch) begin
            cyc(7);
            ps2_clk = 1'b0;
            cyc(2);
            ps2_clk = 1'b1;
            cyc(H - 9);
        end else begin
            cyc(H);
        end
        ps2_clk = 1'b0;
        if (rd_at_fall) begin
            cyc(6);
            bus.io_re = 1'b1;
            bus.io_a  = 2'd0;
            cyc();
            bus.io_re = 1'b0;
            cyc(H - 7);
        end else begin
            cyc(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits, input bit rd_last);
        logic [10:0] f;
        logic        p;
        p = (~^d) ^ bad_par;
        f = {~bad_stop, p, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], glitch && (i == 4), rd_last && (i == 10));
        ps2_data = 1'b1;
        if (nbits == 11 && m_en) begin
            if (bad_par || bad_stop)      m_perr = 1;
            else if (m_fifo.size() < 4)   m_fifo.push_back(d);
            else                          m_ovf = 1;
        end
        cyc(4);
    endtask

    task automatic frame(input logic [7:0] d);
        send_frame(d, 0, 0, 0, 11, 0);
    endtask

    initial begin
        int r;
        bus.io_re  = 1'b0;
        bus.io_we  = 1'b0;
        bus.io_a   = 2'd0;
        bus.io_din = 8'h00;

        cyc(3);
        rst = 1'b1;
        cyc(4);
        for (int a = 0; a < 4; a++) bus_read(2'(a));
        check_irq();

        bus_write(2'd2, 8'h03);
        frame(8'h1C);
        bus_read(2'd1);
        check_irq();
        bus_read(2'd0);
        bus_read(2'd1);
        check_irq();

        for (int i = 1; i <= 5; i++) frame(8'(i));
        bus_read(2'd1);
        for (int i = 0; i < 5; i++) bus_read(2'd0);
        bus_write(2'd1, 8'h02);
        bus_read(2'd1);

        send_frame(8'h1C, 1, 0, 0, 11, 0);
        bus_read(2'd1);
        bus_write(2'd1, 8'h04);
        send_frame(8'h5E, 0, 1, 0, 11, 0);
        bus_read(2'd1);
        bus_write(2'd1, 8'h04);
        bus_read(2'd1);

        send_frame(8'h5A, 0, 0, 1, 11, 0);
        bus_read(2'd0);

        send_frame(8'h0F, 0, 0, 0, 4, 0);
        cyc(TIMEOUT + 50);
        frame(8'hAA);
        bus_read(2'd1);
        bus_read(2'd0);
        bus_read(2'd0);

        for (int i = 0; i < 4; i++) frame(8'h60 + 8'(i));
        send_frame(8'h64, 0, 0, 0, 11, 1);
        bus_read(2'd1);
        check_irq();
        for (int i = 0; i < 5; i++) bus_read(2'd0);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: send_frame(8'($urandom), $urandom_range(0, 7) == 0,
                                       $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 11, 0);
                4, 5:    bus_read(2'd0);
                6:       bus_read(2'd1);
                7:       bus_read(2'($urandom_range(2, 3)));
                8:       bus_write(2'd1, 8'($urandom));
                default: bus_write(2'd2, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03);
            endcase
            check_irq();
        end

        bus_write(2'd2, 8'h03);
        frame(8'h33);
        check_irq();
        send_frame(8'hC3, 0, 0, 0, 4, 0);
        rst = 1'b0;
        m_fifo.delete();
        m_ovf = 0; m_perr = 0; m_en = 0; m_rxie = 0;
        #1;
        check_irq();
        for (int a = 0; a < 4; a++) bus_read(2'(a));
        rst = 1'b1;
        cyc(4);
        bus_read(2'd1);
        bus_read(2'd2);
        check_irq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
